shift_engine: RTL

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine.sv | 90 +++++++++
 1 files changed

// File: rtl/shift_engine.sv
// Iterative 32-bit shifter: one 1-bit step per clock for SLL, SRL, SRA and ROR.
// Operands are captured only on an accepted start in IDLE; result is the work register.
module shift_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            work_q  <= 32'h0000_0000;
            cnt_q   <= 5'd0;
            op_q    <= OpSll;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Single-bit step of the latched operation.
    always_comb begin
        step = work_q;
        unique case (op_q)
            OpSll: step = {work_q[30:0], 1'b0};
            OpSrl: step = {1'b0, work_q[31:1]};
            OpSra: step = {work_q[31], work_q[31:1]};
            OpRor: step = {work_q[0], work_q[31:1]};
            default: step = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = data_in;
                    op_d    = op;
                    cnt_d   = shamt;
                    state_d = (shamt != 5'd0) ? StShift : StDone;
                end
            end
            StShift: begin
                work_d = step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        result = work_q;
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
    end

endmodule
